// File: rtl/ddr3_traffic_master.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_traffic_master
// Description : Self-test initiator for the DDR3 controller user interface.
//               Writes NUM_WORDS words of an address-derived pattern, reads
//               them back with a bounded number of reads in flight, drains
//               the return FIFO and checks every returned address/data pair.
//               Optional watchdog enabled by defining DDR3_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_traffic_master #(
    parameter int          NUM_WORDS       = 64,
    parameter logic [25:0] BASE_ADDR       = 26'h0,
    parameter logic [15:0] SEED            = 16'hA5C3,
    parameter logic [1:0]  SZ_VAL          = 2'b00,
    parameter logic [2:0]  OP_VAL          = 3'b000,
    parameter int          MAX_OUTSTANDING = 16,
    parameter int          TIMEOUT_CYCLES  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ctrl_ready,
    input  logic        notfull,
    output logic [2:0]  cmd,
    output logic [25:0] addr,
    output logic [1:0]  sz,
    output logic [2:0]  op,
    output logic [15:0] din,
    output logic        read,
    input  logic        validout,
    input  logic [25:0] raddr,
    input  logic [15:0] dout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [25:0] first_err_addr,
    output logic        timeout
);

    localparam logic [2:0]  c_CMD_NOP   = 3'b000;
    localparam logic [2:0]  c_CMD_SCR   = 3'b001;
    localparam logic [2:0]  c_CMD_SCW   = 3'b010;
    localparam logic [12:0] c_NUM_WORDS = 13'(NUM_WORDS);
    localparam logic [5:0]  c_MAX_OUT   = 6'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_WRITE    = 3'd2,
        S_READ     = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [2:0]  r_cmd;
    logic [25:0] r_addr;
    logic [15:0] r_din;
    logic        r_read;
    logic [12:0] r_wr_idx;          // SCW commands placed on the bus
    logic [12:0] r_rd_idx;          // SCR commands placed on the bus
    logic [12:0] r_ret_idx;         // valid returns consumed
    logic [5:0]  r_outstanding;     // SCR accepted but not yet returned
    logic [15:0] r_err_count;
    logic [25:0] r_first_err_addr;

    logic        w_busy;
    logic        w_start_ok;
    logic        w_accept;
    logic        w_scr_acc;
    logic        w_bus_free;
    logic        w_pop_err;
    logic        w_pop_ok;
    logic        w_mismatch;
    logic        w_wdog_fire;
    logic        w_timeout;
    logic [5:0]  w_out_next;
    logic [25:0] w_wr_addr;
    logic [25:0] w_rd_addr;
    logic [25:0] w_exp_addr;

    assign w_busy     = (r_state == S_WAIT_RDY) || (r_state == S_WRITE) ||
                        (r_state == S_READ)     || (r_state == S_DRAIN);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // The controller's put is combinational on cmd & notfull.
    assign w_accept   = (r_cmd != c_CMD_NOP) && notfull;
    assign w_scr_acc  = w_accept && (r_cmd == c_CMD_SCR);
    // A new command may be loaded only when nothing un-accepted is on the bus.
    assign w_bus_free = (r_cmd == c_CMD_NOP) || notfull;

    // A pop happens in the cycle read is high; with nothing outstanding it is bogus.
    assign w_pop_err  = r_read && (r_outstanding == 6'd0);
    assign w_pop_ok   = r_read && !w_pop_err;

    // Occupancy after this cycle's accept/pop; gates issuing the next SCR.
    assign w_out_next = r_outstanding + {5'd0, w_scr_acc} - {5'd0, w_pop_ok};

    // 26-bit modulo address arithmetic.
    assign w_wr_addr  = BASE_ADDR + 26'(r_wr_idx);
    assign w_rd_addr  = BASE_ADDR + 26'(r_rd_idx);
    assign w_exp_addr = BASE_ADDR + 26'(r_ret_idx);

    assign w_mismatch = w_pop_err ||
                        (w_pop_ok && ((raddr != w_exp_addr) ||
                                      (dout != (w_exp_addr[15:0] ^ SEED))));

`ifdef DDR3_MASTER_TIMEOUT_EN
    localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog;
    logic        r_timeout;

    assign w_wdog_fire = w_busy && !w_accept && !r_read && (r_wdog >= c_WDOG_LAST);
    assign w_timeout   = r_timeout;

    // Watchdog: restart on any accept or pop, count stalled cycles while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog    <= 16'd0;
            r_timeout <= 1'b0;
        end else if (w_start_ok) begin
            r_wdog    <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_wdog_fire) begin
                r_timeout <= 1'b1;
            end
            if (!w_busy || w_accept || r_read) begin
                r_wdog <= 16'd0;
            end else begin
                r_wdog <= r_wdog + 16'd1;
            end
        end
    end
`else
    // No watchdog in this build: it never fires and TIMEOUT_CYCLES is inert.
    assign w_wdog_fire = (TIMEOUT_CYCLES < 0);
    assign w_timeout   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a watchdog expiry overrides every busy state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_next = S_WAIT_RDY;
            S_WAIT_RDY: if (ctrl_ready) w_state_next = S_WRITE;
            S_WRITE:    if (w_accept && (r_wr_idx == c_NUM_WORDS)) w_state_next = S_READ;
            S_READ:     if (w_accept && (r_rd_idx == c_NUM_WORDS)) w_state_next = S_DRAIN;
            S_DRAIN:    if (r_ret_idx == c_NUM_WORDS) w_state_next = S_DONE;
            S_DONE:     if (start) w_state_next = S_WAIT_RDY;
            default:    w_state_next = S_IDLE;
        endcase
        if (w_wdog_fire) begin
            w_state_next = S_DONE;
        end
    end

    // Command bus: hold until accepted, then load the next SCW/SCR or NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd    <= c_CMD_NOP;
            r_addr   <= 26'd0;
            r_din    <= 16'd0;
            r_wr_idx <= 13'd0;
            r_rd_idx <= 13'd0;
        end else if (w_start_ok) begin
            r_cmd    <= c_CMD_NOP;
            r_wr_idx <= 13'd0;
            r_rd_idx <= 13'd0;
        end else if (w_wdog_fire) begin
            r_cmd <= c_CMD_NOP;
        end else if (w_bus_free) begin
            r_cmd <= c_CMD_NOP;
            if ((r_state == S_WRITE) && (r_wr_idx != c_NUM_WORDS)) begin
                r_cmd    <= c_CMD_SCW;
                r_addr   <= w_wr_addr;
                r_din    <= w_wr_addr[15:0] ^ SEED;
                r_wr_idx <= r_wr_idx + 13'd1;
            end else if ((r_state == S_READ) && (r_rd_idx != c_NUM_WORDS) &&
                         (w_out_next < c_MAX_OUT)) begin
                r_cmd    <= c_CMD_SCR;
                r_addr   <= w_rd_addr;
                r_rd_idx <= r_rd_idx + 13'd1;
            end
        end
    end

    // Return path: pop at most every other cycle, check in order, track errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read           <= 1'b0;
            r_ret_idx        <= 13'd0;
            r_outstanding    <= 6'd0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= 26'd0;
        end else if (w_start_ok) begin
            r_read           <= 1'b0;
            r_ret_idx        <= 13'd0;
            r_outstanding    <= 6'd0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= 26'd0;
        end else begin
            r_read        <= ((r_state == S_READ) || (r_state == S_DRAIN)) &&
                             validout && !r_read && !w_wdog_fire;
            r_outstanding <= w_out_next;
            if (w_pop_ok) begin
                r_ret_idx <= r_ret_idx + 13'd1;
            end
            if (w_mismatch) begin
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                if (r_err_count == 16'd0) begin
                    r_first_err_addr <= raddr;
                end
            end
        end
    end

    assign cmd            = r_cmd;
    assign addr           = r_addr;
    assign sz             = SZ_VAL;
    assign op             = OP_VAL;
    assign din            = r_din;
    assign read           = r_read;
    assign busy           = w_busy;
    assign done           = (r_state == S_DONE);
    assign pass           = (r_state == S_DONE) && (r_err_count == 16'd0) && !w_timeout;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign timeout        = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_traffic_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_traffic_master
// Description : Scoreboard bench for ddr3_traffic_master with a small DDR3
//               controller model (memory, delayed in-order return FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_traffic_master;

    localparam logic [2:0] c_NOP = 3'b000;
    localparam logic [2:0] c_SCR = 3'b001;
    localparam logic [2:0] c_SCW = 3'b010;

    logic        clk = 1'b0;
    logic        reset, start, ctrl_ready, notfull, validout;
    logic [25:0] raddr;
    logic [15:0] dout;
    logic [2:0]  cmd;
    logic [25:0] addr;
    logic [1:0]  sz;
    logic [2:0]  op;
    logic [15:0] din;
    logic        read, busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [25:0] first_err_addr;

    always #5 clk = ~clk;

    ddr3_traffic_master #(
        .NUM_WORDS      (6),
        .BASE_ADDR      (26'h3FFFFFE),
        .SEED           (16'hA5C3),
        .SZ_VAL         (2'b00),
        .OP_VAL         (3'b000),
        .MAX_OUTSTANDING(2),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ctrl_ready    (ctrl_ready),
        .notfull       (notfull),
        .cmd           (cmd),
        .addr          (addr),
        .sz            (sz),
        .op            (op),
        .din           (din),
        .read          (read),
        .validout      (validout),
        .raddr         (raddr),
        .dout          (dout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .timeout       (timeout)
    );

    typedef struct packed {
        logic [2:0]  c;
        logic [25:0] a;
        logic [15:0] d;
    } cmd_t;

    typedef struct packed {
        logic        p;
        logic [15:0] e;
        logic [25:0] f;
        logic        t;
    } stat_t;

    typedef struct {
        logic [25:0] a;
        logic [15:0] d;
        int          due;
    } ret_t;

    cmd_t  exp_cmd_q[$];
    stat_t exp_stat_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    logic [25:0] tbl_addr [6];
    logic [15:0] tbl_din  [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- controller model ----------------
    int          cyc = 0;
    int          ret_delay = 2;
    logic        corrupt_en = 1'b0;
    int          mdl_out = 0;
    int          max_out = 0;
    ret_t        inflight_q[$];
    ret_t        fifo_q[$];
    logic [15:0] mem [logic [25:0]];

    always @(posedge clk) begin
        ret_t e;
        cyc = cyc + 1;
        if (reset) begin
            inflight_q.delete();
            fifo_q.delete();
            mdl_out = 0;
            validout <= 1'b0;
            raddr    <= 26'd0;
            dout     <= 16'd0;
        end else begin
            if (start) max_out = 0;
            if (read && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                mdl_out--;
            end
            if (cmd == c_SCW && notfull) mem[addr] = din;
            if (cmd == c_SCR && notfull) begin
                e.a = addr;
                e.d = mem.exists(addr) ? mem[addr] : 16'hDEAD;
                if (corrupt_en && addr == 26'h2) e.d = e.d ^ 16'h0001;
                e.due = cyc + ret_delay;
                inflight_q.push_back(e);
                mdl_out++;
                if (mdl_out > max_out) max_out = mdl_out;
            end
            while (inflight_q.size() > 0 && inflight_q[0].due <= cyc)
                fifo_q.push_back(inflight_q.pop_front());
            validout <= (fifo_q.size() > 0);
            raddr    <= (fifo_q.size() > 0) ? fifo_q[0].a : 26'd0;
            dout     <= (fifo_q.size() > 0) ? fifo_q[0].d : 16'd0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic done_q = 1'b0;
    logic hold_pending = 1'b0;
    cmd_t held;

    always @(negedge clk) begin
        cmd_t  ec;
        stat_t es;
        if (!reset) begin
            if (hold_pending) begin
                chk("hold_cmd_addr_din", {3'd0, cmd, addr}, {3'd0, held.c, held.a});
                chk("hold_din", {16'd0, din}, {16'd0, held.d});
                hold_pending = 1'b0;
            end
            if (cmd != c_NOP && notfull) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {29'd0, cmd}, 32'd0);
                end else begin
                    ec = exp_cmd_q.pop_front();
                    chk("cmd_type", {29'd0, cmd}, {29'd0, ec.c});
                    chk("cmd_addr", {6'd0, addr}, {6'd0, ec.a});
                    if (ec.c == c_SCW) chk("cmd_din", {16'd0, din}, {16'd0, ec.d});
                    if (cmd == c_SCR) chk("outstanding_below_max", (mdl_out < 2) ? 32'd1 : 32'd0, 32'd1);
                end
            end
            if (cmd != c_NOP && !notfull) begin
                hold_pending = 1'b1;
                held = '{c: cmd, a: addr, d: din};
            end
            if (done && !done_q) begin
                if (exp_stat_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    es = exp_stat_q.pop_front();
                    chk("pass", {31'd0, pass}, {31'd0, es.p});
                    chk("err_count", {16'd0, err_count}, {16'd0, es.e});
                    chk("first_err_addr", {6'd0, first_err_addr}, {6'd0, es.f});
                    chk("timeout", {31'd0, timeout}, {31'd0, es.t});
                    chk("all_cmds_seen", exp_cmd_q.size(), 32'd0);
                    chk("sz_op", {27'd0, sz, op}, 32'd0);
                end
            end
        end
        done_q = done;
    end

    // ---------------- stimulus ----------------
    task automatic load_exp();
        for (int i = 0; i < 6; i++) exp_cmd_q.push_back('{c: c_SCW, a: tbl_addr[i], d: tbl_din[i]});
        for (int i = 0; i < 6; i++) exp_cmd_q.push_back('{c: c_SCR, a: tbl_addr[i], d: 16'h0});
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_clear_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done) break;
        end
        if (!done) chk("done_within_budget", 32'd0, 32'd1);
        @(negedge clk);
        @(posedge clk); #2;
    endtask

    task automatic run(input int dly, input logic corr, input stat_t st, input logic stall);
        int i;
        ret_delay  = dly;
        corrupt_en = corr;
        load_exp();
        exp_stat_q.push_back(st);
        pulse_start();
        if (stall) begin
            for (i = 0; i < 100; i++) begin
                @(posedge clk); #2;
                if (cmd == c_SCW && addr == tbl_addr[2]) break;
            end
            chk("stall_target_seen", (i < 100) ? 32'd1 : 32'd0, 32'd1);
            notfull = 1'b0;
            repeat (3) @(posedge clk);
            #2 notfull = 1'b1;
        end
        wait_done(1000);
    endtask

    initial begin
        stat_t st_ok, st_bad;
        int    i;
        tbl_addr[0] = 26'h3FFFFFE; tbl_din[0] = 16'h5A3D;
        tbl_addr[1] = 26'h3FFFFFF; tbl_din[1] = 16'h5A3C;
        tbl_addr[2] = 26'h0000000; tbl_din[2] = 16'hA5C3;
        tbl_addr[3] = 26'h0000001; tbl_din[3] = 16'hA5C2;
        tbl_addr[4] = 26'h0000002; tbl_din[4] = 16'hA5C1;
        tbl_addr[5] = 26'h0000003; tbl_din[5] = 16'hA5C0;
        st_ok  = '{p: 1'b1, e: 16'd0, f: 26'd0, t: 1'b0};
        st_bad = '{p: 1'b0, e: 16'd1, f: 26'h2, t: 1'b0};

        reset = 1'b1; start = 1'b0; ctrl_ready = 1'b0; notfull = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", {29'd0, cmd}, 32'd0);
        chk("rst_addr_din", {addr, din[5:0]}, 32'd0);
        chk("rst_read_busy_done", {29'd0, read, busy, done}, 32'd0);
        chk("rst_pass_timeout", {30'd0, pass, timeout}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_first_err_addr", {6'd0, first_err_addr}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;

        // Ideal controller, but ctrl_ready held low first: no commands may appear.
        ret_delay = 2;
        load_exp();
        exp_stat_q.push_back(st_ok);
        pulse_start();
        repeat (5) @(posedge clk);
        #2 chk("no_cmd_before_ready", {29'd0, cmd}, 32'd0);
        ctrl_ready = 1'b1;
        wait_done(1000);

        // Re-run from DONE with notfull dropped for 3 cycles mid-write.
        run(2, 1'b0, st_ok, 1'b1);

        // Slow returns, corrupted word at address 2, MAX_OUTSTANDING=2.
        run(20, 1'b1, st_bad, 1'b0);
        chk("outstanding_reached_max", max_out, 32'd2);

        // Reset in the middle of READ.
        ret_delay  = 20;
        corrupt_en = 1'b1;
        load_exp();
        pulse_start();
        for (i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (cmd == c_SCR) break;
        end
        chk("read_phase_reached", (i < 200) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cmd", {29'd0, cmd}, 32'd0);
        chk("midrst_read_busy", {30'd0, read, busy}, 32'd0);
        chk("midrst_err_count", {16'd0, err_count}, 32'd0);
        #1 reset = 1'b0;
        exp_cmd_q.delete();
        corrupt_en = 1'b0;

        // Clean run starting from IDLE after the abort.
        run(3, 1'b0, st_ok, 1'b0);

        chk("all_status_seen", exp_stat_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
